// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operation request in, result and flags out.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] tr;
  logic [WIDTH-1:0] sr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dr;
  logic             cf;
  logic             of;
  logic             zf;
  logic             nf;

  modport master (
    output in_valid, op, tr, sr, out_ready,
    input  in_ready, out_valid, dr, cf, of, zf, nf
  );

  modport slave (
    input  in_valid, op, tr, sr, out_ready,
    output in_ready, out_valid, dr, cf, of, zf, nf
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic, bit-serial shifts and a shift-add multiplier
// behind a valid/ready request and result handshake.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;
  localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_CMP = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NEG = 4'h6, OP_NOT = 4'h7,
    OP_SLL = 4'h8, OP_SLA = 4'h9, OP_SRL = 4'hA, OP_SRA = 4'hB,
    OP_MUL = 4'hC
  } op_t;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] wa;     // shift operand, or multiplier / product low half
  logic [WIDTH-1:0] wb;     // product high half
  logic [WIDTH-1:0] mcand;
  logic [SHW:0]     cnt;
  logic             c_st, o_st;
  logic [WIDTH-1:0] dr_q;
  logic             cf_q, of_q, zf_q, nf_q;

  logic [SHW-1:0]   shamt;
  logic             is_shift, is_mul, multi, accept;

  assign shamt    = bus.sr[SHW-1:0];
  assign is_shift = (bus.op[3:2] == 2'b10);
  assign is_mul   = (bus.op == OP_MUL);
  assign multi    = is_mul | (is_shift & (shamt != '0));
  assign accept   = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = (state == IDLE) & rst_n;
  assign bus.out_valid = (state == DONE);
  assign bus.dr        = dr_q;
  assign bus.cf        = cf_q;
  assign bus.of        = of_q;
  assign bus.zf        = zf_q;
  assign bus.nf        = nf_q;

  // Single-cycle result, evaluated on the live request at the accept edge.
  logic [WIDTH-1:0] r_dr;
  logic             r_cf, r_of, r_legal;

  always_comb begin
    r_dr    = '0;
    r_cf    = 1'b0;
    r_of    = 1'b0;
    r_legal = 1'b1;
    case (bus.op)
      OP_ADD: begin
        {r_cf, r_dr} = {1'b0, bus.tr} + {1'b0, bus.sr};
        r_of = (bus.tr[M] == bus.sr[M]) & (r_dr[M] != bus.tr[M]);
      end
      OP_SUB: begin
        r_dr = bus.tr - bus.sr;
        r_cf = (bus.tr < bus.sr);
        r_of = (bus.tr[M] != bus.sr[M]) & (r_dr[M] != bus.tr[M]);
      end
      OP_CMP: r_dr = {{(WIDTH-1){1'b0}}, (bus.tr == bus.sr)};
      OP_AND: r_dr = bus.tr & bus.sr;
      OP_OR:  r_dr = bus.tr | bus.sr;
      OP_XOR: r_dr = bus.tr ^ bus.sr;
      OP_NEG: r_dr = ~bus.tr + 1'b1;
      OP_NOT: r_dr = ~bus.tr;
      OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_MUL: r_dr = bus.tr;
      default: r_legal = 1'b0;
    endcase
  end

  // One serial step: a single shift position, or one multiplier bit of shift-add.
  logic [WIDTH-1:0] s_val;
  logic             s_cf, s_of;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH-1:0] f_dr;
  logic             f_cf, f_of;

  always_comb begin
    s_val = wa;
    s_cf  = c_st;
    s_of  = o_st;
    case (op_q)
      OP_SLL, OP_SLA: begin
        s_val = {wa[M-1:0], 1'b0};
        s_cf  = wa[M];
        if ((op_q == OP_SLA) && (wa[M] != wa[M-1])) s_of = 1'b1;
      end
      OP_SRL: begin
        s_val = {1'b0, wa[M:1]};
        s_cf  = wa[0];
      end
      OP_SRA: begin
        s_val = {wa[M], wa[M:1]};
        s_cf  = wa[0];
      end
      default: ;
    endcase

    mul_sum  = {1'b0, wb} + (wa[0] ? {1'b0, mcand} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], wa[M:1]};

    if (op_q == OP_MUL) begin
      f_dr = mul_lo_n;
      f_cf = (mul_hi_n != '0);
      f_of = 1'b0;
    end else begin
      f_dr = s_val;
      f_cf = s_cf;
      f_of = s_of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = multi ? BUSY : DONE;
      BUSY: if (cnt == (SHW+1)'(1)) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      wa    <= '0;
      wb    <= '0;
      mcand <= '0;
      cnt   <= '0;
      c_st  <= 1'b0;
      o_st  <= 1'b0;
      dr_q  <= '0;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
      zf_q  <= 1'b0;
      nf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= bus.op;
          c_st <= 1'b0;
          o_st <= 1'b0;
          if (multi) begin
            if (is_mul) begin
              wa    <= bus.sr;
              wb    <= '0;
              mcand <= bus.tr;
              cnt   <= MUL_CNT;
            end else begin
              wa  <= bus.tr;
              cnt <= {1'b0, shamt};
            end
          end else begin
            dr_q <= r_dr;
            cf_q <= r_cf;
            of_q <= r_of;
            zf_q <= r_legal & (r_dr == '0);
            nf_q <= r_dr[M];
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (op_q == OP_MUL) begin
            wa <= mul_lo_n;
            wb <= mul_hi_n;
          end else begin
            wa   <= s_val;
            c_st <= s_cf;
            o_st <= s_of;
          end
          if (cnt == (SHW+1)'(1)) begin
            dr_q <= f_dr;
            cf_q <= f_cf;
            of_q <= f_of;
            zf_q <= (f_dr == '0);
            nf_q <= f_dr[M];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; SHALL be a power of two, minimum 8.
REQ-002 Derived constant SHW = log2(WIDTH): shift-amount width; SHALL NOT be overridable.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept an operation.
REQ-007 op  in  4  opcode, per REQ-012.
REQ-008 tr  in  WIDTH  first operand.
REQ-009 sr  in  WIDTH  second operand; shift amount is sr[SHW-1:0].
REQ-010 out_valid  out  1 / out_ready  in  1  result handshake.
REQ-011 dr  out  WIDTH, cf, of, zf, nf  out  1 each: result and flags, stable while out_valid=1.

Function
REQ-012 Opcodes: 0000 add, 0001 sub, 0010 cmp (dr=1 if tr==sr, else 0), 0011 and, 0100 or, 0101 xor, 0110 neg (~tr+1), 0111 not (~tr), 1000 sll, 1001 sla, 1010 srl, 1011 sra, 1100 mul (unsigned, low WIDTH bits); 1101-1111 illegal: dr=0, all flags 0.
REQ-013 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 Accept = in_valid & in_ready at a rising edge; op, tr, sr captured at that edge, later input changes ignored.
REQ-015 Single-cycle ops (0000-0111, 1101-1111, and shifts with amount 0): IDLE->DONE at accept edge; out_valid asserted the next cycle.
REQ-016 Shifts with amount n>0: IDLE->BUSY at accept; one bit per cycle for n cycles; BUSY->DONE at nth BUSY edge; accept-to-out_valid latency n+1 cycles.
REQ-017 mul: shift-add, one multiplier bit per cycle, exactly WIDTH BUSY cycles; latency WIDTH+1.
REQ-018 DONE->IDLE at the edge where out_ready=1; no new accept in that same edge; back-to-back throughput one op per (latency+1) cycles minimum.
REQ-019 out_ready=0 in DONE: hold dr and flags unchanged indefinitely.
REQ-020 add: cf = carry out of bit WIDTH-1; of = signed overflow.
REQ-021 sub: cf = borrow (1 iff tr<sr unsigned); of = signed overflow.
REQ-022 sll/sla/srl/sra: cf = last bit shifted out (0 when n=0); sll/srl/sra of=0; sla of=1 iff the sign bit changed at any step; sra fills with original tr[WIDTH-1], srl/sll/sla fill with 0.
REQ-023 mul: cf = 1 iff full 2*WIDTH product upper half nonzero; of=0.
REQ-024 Logic, cmp, neg, not: cf=0, of=0.
REQ-025 All ops: zf = (dr==0), nf = dr[WIDTH-1], computed on final result.
REQ-026 Shift amount uses sr[SHW-1:0] only; upper sr bits ignored (shift by WIDTH+3 == shift by 3).

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, dr=0, cf=of=zf=nf=0, out_valid=0, counters 0.
REQ-028 in_ready SHALL be 0 while rst_n=0 and 1 in first cycle after deassertion.
REQ-029 Reset in BUSY or DONE SHALL discard the operation; no out_valid produced for it.

Verification
REQ-030 WIDTH=32, add tr=0x7FFFFFFF, sr=1 -> 1 cycle later dr=0x80000000, of=1, cf=0, nf=1, zf=0.
REQ-031 sub tr=0, sr=1 -> dr=0xFFFFFFFF, cf=1, of=0, nf=1.
REQ-032 sra tr=0x80000001, sr=0x21 (n=1) -> out_valid after 2 cycles, dr=0xC0000000, cf=1; sla tr=0x40000000, sr=1 -> dr=0x80000000, of=1.
REQ-033 mul tr=0x00010000, sr=0x00010000 -> out_valid after 33 cycles, dr=0, zf=1, cf=1; hold out_ready=0 for 5 cycles -> dr/flags stable, in_ready=0.
REQ-034 Accept sll n=10, assert rst_n=0 at BUSY cycle 4 -> outputs zero immediately, no out_valid; after release, add 2+3 -> dr=5.
REQ-035 Illegal op 1110 with tr=sr=0xFFFFFFFF -> dr=0, all flags 0 (zf=0), 1-cycle latency.
